tap_exe_mc: RTL and testbench
=============================

Name: tap_exe_mc

Overview:
- Multi-channel successor to the single tap command executor.
- Decodes 32-bit commands addressed to the tap target and holds per-channel threshold, compare-mode, trigger-enable and holdoff settings.
- Runs a per-channel threshold trigger state machine on incoming samples, with a saturating trigger counter per channel.
- Sits between the command dispatcher (run/cmd/rsp) and the ADC sample path; its trigger outputs feed the readout logic.

Parameters:
- N_CH, 4, number of channels (1..15).
- DW, 14, sample and threshold width (1..16).
- CW, 16, trigger counter width (1..16).
- TARGET_ID, 4'h3, value of cmd[31:28] that selects this block.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- run  in  1  single-cycle strobe; cmd is valid while it is high.
- cmd  in  32  command word: [31:28] target, [27:20] instr, [19:16] channel, [15:0] data.
- rsp  out  32  response word.
- rsp_valid  out  1  one-cycle pulse marking a new rsp.
- smp_valid  in  1  sample strobe, common to all channels.
- smp  in  N_CH*DW  channel samples, unsigned; channel c is at [c*DW +: DW].
- trig  out  N_CH  per-channel one-cycle trigger pulses.

Behaviour:
- Reset values: rsp=0, rsp_valid=0, trig=0. Every channel: mode=3'b001 (GT), thr=0, trig_en=0, holdoff=0, cnt=0, state IDLE.
- Command acceptance: a command is accepted only when run=1 and cmd[31:28]==TARGET_ID.
  - Any other target: no state change and no rsp_valid.
  - Accepted command: rsp and rsp_valid are registered, one cycle of latency. There is no busy signal; run may be high on every cycle.
- Instruction set (ch = cmd[19:16]). For SET instructions, ch=4'hF broadcasts to all channels.
  - 0x01 SET_MODE: mode <= data[2:0], encoded {LT,ET,GT}; rsp=cmd.
  - 0x02 SET_THR: thr <= data[DW-1:0]; rsp=cmd.
  - 0x03 SET_TRIG_EN: trig_en <= data[0]; rsp=cmd.
  - 0x04 SET_HOLDOFF: holdoff <= data[15:0]; rsp=cmd.
  - 0x10 GET_THR: rsp={cmd[31:16], thr zero-extended to 16 bits}.
  - 0x11 GET_MODE: rsp={cmd[31:16], 12'b0, trig_en, mode}.
  - 0x12 GET_CNT: rsp={cmd[31:16], cnt zero-extended to 16 bits}.
  - 0x20 CLR_CNT: cnt <= 0; ch=4'hF clears all channels; rsp=cmd.
- Errors: an unknown instr, a ch >= N_CH other than 4'hF, or a GET with ch=4'hF changes no state. rsp={4'hE, cmd[27:0]}, with rsp_valid still pulsed.
- Per-channel hit: hit = (GT & smp>thr) | (ET & smp==thr) | (LT & smp<thr), evaluated only when smp_valid=1. mode=0 never hits.
- Per-channel FSM, states IDLE, HOLD (plus REARM, see Optional Feature):
  - IDLE: if trig_en & smp_valid & hit, then on the next edge trig=1 for one cycle, cnt is incremented (saturating at 2^CW-1), hcnt <= holdoff, and the FSM goes to HOLD, or stays in IDLE if holdoff==0.
  - HOLD: hcnt decrements every clk; at hcnt==1 the FSM returns to IDLE. Holdoff=N therefore blocks exactly N cycles after the trigger edge.
  - trig_en=0 forces IDLE from any state on the next edge; cnt is kept.
- Latency: trig is asserted on the first edge after the qualifying sample. With holdoff=0, back-to-back hits produce trig on consecutive cycles.
- Configuration writes take effect for samples on the cycle after the write edge. A holdoff write during HOLD does not alter the current hcnt.
- A CLR_CNT and a trigger on the same channel in the same cycle: the clear wins and cnt=0. The trig pulse is still emitted.
- Asynchronous reset mid-holdoff returns to the reset values immediately; trig deasserts without waiting for a clock.

Optional Feature:
- Macro: TAP_REARM_EN.
- Defined: adds state REARM. HOLD expiry (or a trigger with holdoff==0) enters REARM instead of IDLE. REARM moves to IDLE only after a smp_valid cycle with hit=0, so a level held above threshold produces a single trigger. GET_MODE returns the state code (IDLE=0, HOLD=1, REARM=2) in rsp[7:6].
- Undefined: the REARM state is absent and rsp[7:6] reads 0.

Test Plan:
- Reset, then GET_MODE ch0 (cmd=0x3110_0000) -> rsp=0x3110_0001 one cycle after run, rsp_valid one cycle wide.
- SET_THR ch2=0x100, SET_MODE ch2=GT, SET_TRIG_EN ch2=1; smp ch2 goes 0x0FF then 0x101 -> trig[2] pulses once, one cycle after 0x101; GET_CNT ch2 -> data 1.
- Holdoff=3, ch2 held at 0x101 for 10 cycles -> trig[2] pulses every 4th cycle without TAP_REARM_EN and exactly once with it; cnt=3 or 1 respectively.
- SET_TRIG_EN broadcast (ch=0xF, data=1) -> all N_CH channels enabled; a command with ch=5 when N_CH=4 -> rsp={0xE, cmd[27:0]}, no state change.
- Target 0x2 with run=1 -> rsp_valid stays 0, no state change; instr 0x7F -> error response.
- Set cnt to all-ones via CW=2 saturation; CLR_CNT issued in the same cycle as a hit -> trig pulses and cnt reads 0.

Source files
------------

// File: rtl/tap_exe_mc.sv
// Multi-channel tap command executor: command decode, per-channel trigger config and threshold trigger FSMs.
// Optional build macro TAP_REARM_EN adds a REARM state that requires a non-hit sample between triggers.
//
// state | meaning
// IDLE  | armed, a qualifying sample fires trig on the next edge
// HOLD  | holdoff countdown after a trigger, hits ignored
// REARM | (TAP_REARM_EN) waits for a valid non-hit sample before arming
module tap_exe_mc #(
  parameter int          N_CH      = 4,
  parameter int          DW        = 14,
  parameter int          CW        = 16,
  parameter logic [3:0]  TARGET_ID = 4'h3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic [31:0]          cmd,
  output logic [31:0]          rsp,
  output logic                 rsp_valid,
  input  logic                 smp_valid,
  input  logic [N_CH*DW-1:0]   smp,
  output logic [N_CH-1:0]      trig
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_REARM = 2'd2
  } st_e;

  localparam logic [4:0] N_CH5 = 5'(N_CH);

  localparam logic [7:0] I_SET_MODE  = 8'h01;
  localparam logic [7:0] I_SET_THR   = 8'h02;
  localparam logic [7:0] I_SET_EN    = 8'h03;
  localparam logic [7:0] I_SET_HOLD  = 8'h04;
  localparam logic [7:0] I_GET_THR   = 8'h10;
  localparam logic [7:0] I_GET_MODE  = 8'h11;
  localparam logic [7:0] I_GET_CNT   = 8'h12;
  localparam logic [7:0] I_CLR_CNT   = 8'h20;

  logic [2:0]    mode_q [N_CH];
  logic [2:0]    mode_d [N_CH];
  logic [DW-1:0] thr_q  [N_CH];
  logic [DW-1:0] thr_d  [N_CH];
  logic          en_q   [N_CH];
  logic          en_d   [N_CH];
  logic [15:0]   hold_q [N_CH];
  logic [15:0]   hold_d [N_CH];
  logic [CW-1:0] cnt_q  [N_CH];
  logic [CW-1:0] cnt_d  [N_CH];
  logic [15:0]   hcnt_q [N_CH];
  logic [15:0]   hcnt_d [N_CH];
  st_e           st_q   [N_CH];
  st_e           st_d   [N_CH];
  logic [N_CH-1:0] trig_q, trig_d;
  logic [N_CH-1:0] clr;
  logic [31:0]   rsp_q, rsp_d;
  logic          rsp_valid_q, rsp_valid_d;

  logic [7:0]    instr;
  logic [3:0]    ch;
  logic          acc, bcast, ch_ok, is_set, is_get, cmd_ok;
  logic [DW-1:0] sel_thr;
  logic [2:0]    sel_mode;
  logic          sel_en;
  logic [CW-1:0] sel_cnt;
  logic [1:0]    sel_st;

  always_comb begin
    instr  = cmd[27:20];
    ch     = cmd[19:16];
    acc    = run && (cmd[31:28] == TARGET_ID);
    bcast  = (ch == 4'hF);
    ch_ok  = ({1'b0, ch} < N_CH5);
    is_set = (instr == I_SET_MODE) || (instr == I_SET_THR) || (instr == I_SET_EN) ||
             (instr == I_SET_HOLD) || (instr == I_CLR_CNT);
    is_get = (instr == I_GET_THR) || (instr == I_GET_MODE) || (instr == I_GET_CNT);
    cmd_ok = (is_set && (bcast || ch_ok)) || (is_get && ch_ok);

    sel_thr  = '0;
    sel_mode = '0;
    sel_en   = 1'b0;
    sel_cnt  = '0;
    sel_st   = 2'b00;
    for (int c = 0; c < N_CH; c++) begin
      if (ch == 4'(c)) begin
        sel_thr  = thr_q[c];
        sel_mode = mode_q[c];
        sel_en   = en_q[c];
        sel_cnt  = cnt_q[c];
`ifdef TAP_REARM_EN
        sel_st   = st_q[c];
`endif
      end
    end

    rsp_d       = rsp_q;
    rsp_valid_d = 1'b0;
    if (acc) begin
      rsp_valid_d = 1'b1;
      if (!cmd_ok) begin
        rsp_d = {4'hE, cmd[27:0]};
      end else begin
        case (instr)
          I_GET_THR:  rsp_d = {cmd[31:16], 16'(sel_thr)};
          I_GET_MODE: rsp_d = {cmd[31:16], 8'h00, sel_st, 2'b00, sel_en, sel_mode};
          I_GET_CNT:  rsp_d = {cmd[31:16], 16'(sel_cnt)};
          default:    rsp_d = cmd;
        endcase
      end
    end

    for (int c = 0; c < N_CH; c++) begin
      mode_d[c] = mode_q[c];
      thr_d[c]  = thr_q[c];
      en_d[c]   = en_q[c];
      hold_d[c] = hold_q[c];
      clr[c]    = 1'b0;
      if (acc && cmd_ok && is_set && (bcast || ch == 4'(c))) begin
        case (instr)
          I_SET_MODE: mode_d[c] = cmd[2:0];
          I_SET_THR:  thr_d[c]  = cmd[DW-1:0];
          I_SET_EN:   en_d[c]   = cmd[0];
          I_SET_HOLD: hold_d[c] = cmd[15:0];
          I_CLR_CNT:  clr[c]    = 1'b1;
          default:    ;
        endcase
      end
    end
  end

  // Channel trigger FSMs; a same-cycle clear overrides the increment but not the pulse.
  always_comb begin
    logic [DW-1:0] s;
    logic          hit;
    for (int c = 0; c < N_CH; c++) begin
      s   = smp[c*DW +: DW];
      hit = smp_valid && ((mode_q[c][0] && (s > thr_q[c])) ||
                          (mode_q[c][1] && (s == thr_q[c])) ||
                          (mode_q[c][2] && (s < thr_q[c])));
      trig_d[c] = 1'b0;
      cnt_d[c]  = cnt_q[c];
      hcnt_d[c] = hcnt_q[c];
      st_d[c]   = st_q[c];
      if (!en_q[c]) begin
        st_d[c] = ST_IDLE;
      end else begin
        case (st_q[c])
          ST_IDLE: begin
            if (hit) begin
              trig_d[c] = 1'b1;
              cnt_d[c]  = (&cnt_q[c]) ? cnt_q[c] : cnt_q[c] + CW'(1);
              hcnt_d[c] = hold_q[c];
              if (hold_q[c] != 16'd0) st_d[c] = ST_HOLD;
`ifdef TAP_REARM_EN
              else                    st_d[c] = ST_REARM;
`endif
            end
          end
          ST_HOLD: begin
            hcnt_d[c] = hcnt_q[c] - 16'd1;
            if (hcnt_q[c] == 16'd1) begin
`ifdef TAP_REARM_EN
              st_d[c] = ST_REARM;
`else
              st_d[c] = ST_IDLE;
`endif
            end
          end
`ifdef TAP_REARM_EN
          ST_REARM: begin
            if (smp_valid && !hit) st_d[c] = ST_IDLE;
          end
`endif
          default: st_d[c] = ST_IDLE;
        endcase
      end
      if (clr[c]) cnt_d[c] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      trig_q      <= '0;
      for (int c = 0; c < N_CH; c++) begin
        mode_q[c] <= 3'b001;
        thr_q[c]  <= '0;
        en_q[c]   <= 1'b0;
        hold_q[c] <= '0;
        cnt_q[c]  <= '0;
        hcnt_q[c] <= '0;
        st_q[c]   <= ST_IDLE;
      end
    end else begin
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
      trig_q      <= trig_d;
      for (int c = 0; c < N_CH; c++) begin
        mode_q[c] <= mode_d[c];
        thr_q[c]  <= thr_d[c];
        en_q[c]   <= en_d[c];
        hold_q[c] <= hold_d[c];
        cnt_q[c]  <= cnt_d[c];
        hcnt_q[c] <= hcnt_d[c];
        st_q[c]   <= st_d[c];
      end
    end
  end

  assign rsp       = rsp_q;
  assign rsp_valid = rsp_valid_q;
  assign trig      = trig_q;

endmodule

// File: tb/tb_tap_exe_mc.sv
// Self-checking bench for tap_exe_mc: response scoreboard plus trigger pulse counting.
// Runs with or without TAP_REARM_EN; CW=2 so counter saturation is reachable.
module tb_tap_exe_mc;
  localparam int N_CH = 4;
  localparam int DW   = 14;
  localparam int CW   = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               run;
  logic [31:0]        cmd;
  logic [31:0]        rsp;
  logic               rsp_valid;
  logic               smp_valid;
  logic [N_CH*DW-1:0] smp;
  logic [N_CH-1:0]    trig;

  int n_chk = 0;
  int n_err = 0;
  int trig_n [N_CH];
  logic [31:0] exp_q [$];

  tap_exe_mc #(.N_CH(N_CH), .DW(DW), .CW(CW), .TARGET_ID(4'h3)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .cmd(cmd), .rsp(rsp),
    .rsp_valid(rsp_valid), .smp_valid(smp_valid), .smp(smp), .trig(trig)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
        else                   chk("rsp", rsp, exp_q.pop_front());
      end
      for (int c = 0; c < N_CH; c++) trig_n[c] += int'(trig[c]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drives run for one cycle; the expected response is queued for the monitor.
  task automatic send(input logic [31:0] c, input logic [31:0] exp, input bit has_rsp);
    run = 1'b1;
    cmd = c;
    if (has_rsp) exp_q.push_back(exp);
    cyc();
    run = 1'b0;
    cmd = '0;
  endtask

  task automatic drive_smp(input int c, input logic [DW-1:0] v);
    smp = '0;
    smp[c*DW +: DW] = v;
    smp_valid = 1'b1;
  endtask

  initial begin
    int t0;
    int exp_hold;
    logic [31:0] exp_mode2;
    for (int c = 0; c < N_CH; c++) trig_n[c] = 0;
    rst_n = 1'b0; run = 1'b0; cmd = '0; smp_valid = 1'b0; smp = '0;
    repeat (2) @(negedge clk);
    chk("rst_rsp", rsp, 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_trig", 32'(trig), 32'h0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // GET_MODE after reset, one-cycle latency and one-cycle pulse
    send(32'h3110_0000, 32'h3110_0001, 1'b1);
    chk("getmode_valid_hi", 32'(rsp_valid), 32'h1);
    cyc();
    chk("getmode_valid_lo", 32'(rsp_valid), 32'h0);

    // Basic threshold trigger on ch2
    send(32'h3022_0100, 32'h3022_0100, 1'b1);
    send(32'h3012_0001, 32'h3012_0001, 1'b1);
    send(32'h3032_0001, 32'h3032_0001, 1'b1);
    t0 = trig_n[2];
    drive_smp(2, 14'h0FF); cyc();
    chk("trig_below", 32'(trig[2]), 32'h0);
    drive_smp(2, 14'h101); cyc();
    chk("trig_above", 32'(trig[2]), 32'h1);
    drive_smp(2, 14'h000); cyc();
    chk("trig_pulse_end", 32'(trig[2]), 32'h0);
    smp_valid = 1'b0; cyc();
    chk("trig_once", 32'(trig_n[2] - t0), 32'd1);
    send(32'h3122_0000, 32'h3122_0001, 1'b1);

    // Holdoff 3 with a level held for 10 samples
    send(32'h3202_0000, 32'h3202_0000, 1'b1);
    send(32'h3042_0003, 32'h3042_0003, 1'b1);
    t0 = trig_n[2];
    for (int i = 0; i < 10; i++) begin
      drive_smp(2, 14'h101);
      cyc();
    end
    smp_valid = 1'b0;
    repeat (6) cyc();
`ifdef TAP_REARM_EN
    exp_hold  = 1;
    exp_mode2 = 32'h3112_0089;
`else
    exp_hold  = 3;
    exp_mode2 = 32'h3112_0009;
`endif
    chk("hold_trigs", 32'(trig_n[2] - t0), 32'(exp_hold));
    send(32'h3122_0000, 32'h3122_0000 | 32'(exp_hold), 1'b1);
    send(32'h3112_0000, exp_mode2, 1'b1);
    drive_smp(2, 14'h000); cyc();
    smp_valid = 1'b0; cyc();

    // Broadcast enable, bad channel, GET broadcast
    send(32'h303F_0001, 32'h303F_0001, 1'b1);
    for (int c = 0; c < N_CH; c++)
      send(32'h3110_0000 | (32'(c) << 16), 32'h3110_0009 | (32'(c) << 16), 1'b1);
    send(32'h3025_0077, 32'hE025_0077, 1'b1);
    send(32'h3100_0000, 32'h3100_0000, 1'b1);
    send(32'h3102_0000, 32'h3102_0100, 1'b1);
    send(32'h310F_0000, 32'hE10F_0000, 1'b1);

    // Foreign target ignored, unknown instruction rejected
    send(32'h2011_0005, 32'h0, 1'b0);
    chk("foreign_no_valid", 32'(rsp_valid), 32'h0);
    send(32'h3111_0000, 32'h3111_0009, 1'b1);
    send(32'h37F0_1234, 32'hE7F0_1234, 1'b1);

    // Saturation on ch1 with CW=2, alternating hit / non-hit
    t0 = trig_n[1];
    for (int i = 0; i < 4; i++) begin
      drive_smp(1, 14'd5); cyc();
      drive_smp(1, 14'd0); cyc();
    end
    smp_valid = 1'b0; cyc();
    chk("sat_trigs", 32'(trig_n[1] - t0), 32'd4);
    send(32'h3121_0000, 32'h3121_0003, 1'b1);

    // CLR_CNT in the same cycle as a hit: pulse kept, count cleared
    t0 = trig_n[1];
    drive_smp(1, 14'd5);
    send(32'h3201_0000, 32'h3201_0000, 1'b1);
    chk("clr_hit_trig", 32'(trig[1]), 32'h1);
    drive_smp(1, 14'd0); cyc();
    smp_valid = 1'b0; cyc();
    chk("clr_hit_count", 32'(trig_n[1] - t0), 32'd1);
    send(32'h3121_0000, 32'h3121_0000, 1'b1);

    // mode 0 never hits, even where ET would
    send(32'h3013_0000, 32'h3013_0000, 1'b1);
    drive_smp(3, 14'd0); cyc();
    drive_smp(3, 14'd9); cyc();
    smp_valid = 1'b0; cyc(); cyc();
    chk("quiet_ch0", 32'(trig_n[0]), 32'd0);
    chk("quiet_ch3", 32'(trig_n[3]), 32'd0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) cyc();
    chk("rsp_drain", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
